xpb_table_gen: RTL and testbench

//  Writer side of the XPB reduction lookup tables. Computes base = 2^shift mod N at run time,

---
 rtl/xpb_table_gen.sv | 125 ++++++++++++
 tb/tb_xpb_table_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/xpb_table_gen.sv
// XPB reduction table writer: computes base = 2^shift mod N, then streams
// j*base mod N for j = 0..2^DIGIT_BITS-1 over a valid/ready write port.
module xpb_table_gen #(
    parameter int MOD_LEN    = 1024,
    parameter int DIGIT_BITS = 5,
    parameter int SHIFT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [MOD_LEN-1:0]    modulus,
    input  logic [SHIFT_W-1:0]    shift,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_en,
    input  logic                  wr_ready,
    output logic [DIGIT_BITS-1:0] wr_addr,
    output logic [MOD_LEN-1:0]    wr_data
);

    typedef enum logic [1:0] {IDLE, POW, WRITE, DONE} state_t;

    localparam logic [DIGIT_BITS-1:0] LAST_J = '1;
    localparam logic [MOD_LEN-1:0]    ONE    = MOD_LEN'(1);

    state_t                  state, state_next;
    logic [MOD_LEN-1:0]      n_reg, r_reg, base_reg, acc_reg;
    logic [SHIFT_W-1:0]      cnt_reg;
    logic [DIGIT_BITS-1:0]   j_reg;
    logic [MOD_LEN:0]        n_ext, dbl, sum;
    logic [MOD_LEN-1:0]      dbl_mod, sum_mod;
    logic                    transfer;

    // One extra bit keeps 2r and acc+base exact before the conditional subtract.
    assign n_ext    = {1'b0, n_reg};
    assign dbl      = {r_reg, 1'b0};
    assign sum      = {1'b0, acc_reg} + {1'b0, base_reg};
    assign dbl_mod  = (dbl >= n_ext) ? MOD_LEN'(dbl - n_ext) : dbl[MOD_LEN-1:0];
    assign sum_mod  = (sum >= n_ext) ? MOD_LEN'(sum - n_ext) : sum[MOD_LEN-1:0];
    assign transfer = (state == WRITE) && wr_ready;

    assign wr_addr = j_reg;
    assign wr_data = acc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = POW;
                end
            end
            POW: begin
                busy = 1'b1;
                if (cnt_reg == '0) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (transfer && (j_reg == LAST_J)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The counter always decrements in POW, so even an illegal N cannot stall the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg    <= '0;
            r_reg    <= '0;
            base_reg <= '0;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            j_reg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg   <= modulus;
                        cnt_reg <= shift;
                        r_reg   <= ONE;
                    end
                end
                POW: begin
                    if (cnt_reg != '0) begin
                        r_reg   <= dbl_mod;
                        cnt_reg <= cnt_reg - SHIFT_W'(1);
                    end else begin
                        base_reg <= r_reg;
                        acc_reg  <= '0;
                        j_reg    <= '0;
                    end
                end
                WRITE: begin
                    if (transfer) begin
                        acc_reg <= sum_mod;
                        j_reg   <= j_reg + DIGIT_BITS'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xpb_table_gen.sv
// Randomized self-checking bench for xpb_table_gen; expected tables come from
// a direct 2^k mod N / j*base mod N model using wide arithmetic.
module tb_xpb_table_gen;

    localparam int MOD_LEN    = 1024;
    localparam int DIGIT_BITS = 5;
    localparam int SHIFT_W    = 16;
    localparam int DEPTH      = 1 << DIGIT_BITS;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [MOD_LEN-1:0]    modulus;
    logic [SHIFT_W-1:0]    shift;
    logic                  busy;
    logic                  done;
    logic                  wr_en;
    logic                  wr_ready;
    logic [DIGIT_BITS-1:0] wr_addr;
    logic [MOD_LEN-1:0]    wr_data;

    int checks   = 0;
    int failures = 0;

    xpb_table_gen #(
        .MOD_LEN(MOD_LEN),
        .DIGIT_BITS(DIGIT_BITS),
        .SHIFT_W(SHIFT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .modulus(modulus),
        .shift(shift),
        .busy(busy),
        .done(done),
        .wr_en(wr_en),
        .wr_ready(wr_ready),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [MOD_LEN-1:0] observed,
                               input logic [MOD_LEN-1:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [MOD_LEN-1:0] modelBase(input logic [MOD_LEN-1:0] n, input int k);
        logic [2*MOD_LEN-1:0] p;
        p    = '0;
        p[k] = 1'b1;
        return MOD_LEN'(p % {{MOD_LEN{1'b0}}, n});
    endfunction

    function automatic logic [MOD_LEN-1:0] modelEntry(input logic [MOD_LEN-1:0] n,
                                                       input logic [MOD_LEN-1:0] base, input int j);
        logic [MOD_LEN+7:0] prod;
        prod = (MOD_LEN+8)'(j) * {8'b0, base};
        return MOD_LEN'(prod % {8'b0, n});
    endfunction

    // One full build: scrambles modulus/shift after acceptance, optionally pokes start
    // during POW, WRITE and DONE, and collects every transfer for comparison.
    task automatic applyStimulus(input logic [MOD_LEN-1:0] n, input int k,
                                 input int ready_pct, input bit poke);
        logic [MOD_LEN-1:0]    base;
        logic [MOD_LEN-1:0]    exp_tab [DEPTH];
        logic [DIGIT_BITS-1:0] addr_q [$];
        logic [MOD_LEN-1:0]    data_q [$];
        logic [DIGIT_BITS-1:0] prev_addr;
        logic [MOD_LEN-1:0]    prev_data;
        bit                    prev_stall;
        int                    first_wr, done_cyc, busy_bad, limit;

        base = modelBase(n, k);
        for (int j = 0; j < DEPTH; j++) exp_tab[j] = modelEntry(n, base, j);
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        first_wr   = -1;
        done_cyc   = -1;
        busy_bad   = 0;
        limit      = k + 2 + DEPTH * 20 + 10;

        @(negedge clk);
        modulus  = n;
        shift    = SHIFT_W'(k);
        start    = 1'b1;
        wr_ready = 1'b1;

        for (int cyc = 1; cyc <= limit && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start   = 1'b0;
                modulus = ~n;
                shift   = SHIFT_W'(k + 7);
            end else begin
                start = poke && (cyc == 2 || cyc == k + 5);
            end
            if (done) begin
                done_cyc = cyc;
                if (busy || wr_en) busy_bad++;
                start = poke;
            end else begin
                if (!busy) busy_bad++;
                if (wr_en) begin
                    if (first_wr < 0) first_wr = cyc;
                    if (prev_stall) begin
                        checkOutput("stall_addr", MOD_LEN'(wr_addr), MOD_LEN'(prev_addr));
                        checkOutput("stall_data", wr_data, prev_data);
                    end
                    wr_ready   = ($urandom_range(99) < ready_pct);
                    prev_stall = !wr_ready;
                    prev_addr  = wr_addr;
                    prev_data  = wr_data;
                    if (wr_ready) begin
                        addr_q.push_back(wr_addr);
                        data_q.push_back(wr_data);
                    end
                end
            end
        end

        if (done_cyc < 0) begin
            checkOutput("done_timeout", '0, MOD_LEN'(1));
        end else begin
            @(negedge clk);
            checkOutput("done_pulse_width", MOD_LEN'(done), '0);
            checkOutput("idle_after_done", MOD_LEN'(busy | wr_en), '0);
            start = 1'b0;
        end

        checkOutput("busy_profile", MOD_LEN'(busy_bad), '0);
        checkOutput("xfer_count", MOD_LEN'(addr_q.size()), MOD_LEN'(DEPTH));
        for (int i = 0; i < addr_q.size() && i < DEPTH; i++) begin
            checkOutput($sformatf("addr[%0d]", i), MOD_LEN'(addr_q[i]), MOD_LEN'(i));
            checkOutput($sformatf("data[%0d]", i), data_q[i], exp_tab[i]);
        end
        if (ready_pct >= 100) begin
            checkOutput("first_wr_cycle", MOD_LEN'(first_wr), MOD_LEN'(k + 2));
            checkOutput("done_cycle", MOD_LEN'(done_cyc), MOD_LEN'(k + 2 + DEPTH));
        end
    endtask

    task automatic resetMidWrite();
        int done_seen;
        int waited;
        done_seen = 0;
        waited    = 0;
        @(negedge clk);
        modulus  = MOD_LEN'(16'hFFF1);
        shift    = SHIFT_W'(3);
        start    = 1'b1;
        wr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!wr_en && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("mid_write_reached", MOD_LEN'(wr_en), MOD_LEN'(1));
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_wr_en", MOD_LEN'(wr_en), '0);
        checkOutput("rst_wr_addr", MOD_LEN'(wr_addr), '0);
        checkOutput("rst_wr_data", wr_data, '0);
        checkOutput("rst_busy", MOD_LEN'(busy), '0);
        rst_n = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (done || wr_en) done_seen++;
        end
        checkOutput("no_done_after_reset", MOD_LEN'(done_seen), '0);
    endtask

    initial begin
        logic [MOD_LEN-1:0] big_n;
        int shifts [3] = '{1024, 1029, 2047};

        rst_n    = 1'b0;
        start    = 1'b0;
        modulus  = '0;
        shift    = '0;
        wr_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", MOD_LEN'(busy), '0);
        checkOutput("reset_done", MOD_LEN'(done), '0);
        checkOutput("reset_wr_en", MOD_LEN'(wr_en), '0);
        checkOutput("reset_wr_addr", MOD_LEN'(wr_addr), '0);
        checkOutput("reset_wr_data", wr_data, '0);
        rst_n = 1'b1;

        applyStimulus(MOD_LEN'(16'hFFF1), 16, 100, 1'b0);
        applyStimulus(MOD_LEN'(37), 5, 100, 1'b0);
        applyStimulus(MOD_LEN'(16'hFFF1), 0, 100, 1'b0);

        applyStimulus(MOD_LEN'(16'hFFF1), $urandom_range(40), 50, 1'b0);
        applyStimulus(MOD_LEN'(37), 9, 50, 1'b0);

        applyStimulus(MOD_LEN'(16'hFFF1), 6, 100, 1'b1);
        resetMidWrite();
        applyStimulus(MOD_LEN'(37), 12, 70, 1'b1);

        foreach (shifts[s]) begin
            for (int w = 0; w < MOD_LEN / 32; w++) big_n[w*32 +: 32] = $urandom;
            big_n[0]         = 1'b1;
            big_n[MOD_LEN-1] = 1'b1;
            applyStimulus(big_n, shifts[s], (s == 0) ? 100 : 60, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
